// File: rtl/lc4_regfile_ss_if.sv
// Bundle of the register-file read, write, allocate and scoreboard signals.
// The master side is decode/writeback; the slave side is the register file.
interface lc4_regfile_ss_if #(
  parameter int n = 16,
  parameter int a = 3
);
  localparam int R = 1 << a;

  logic         gwe;
  logic [a-1:0] i_rs_A;
  logic [a-1:0] i_rt_A;
  logic [a-1:0] i_rs_B;
  logic [a-1:0] i_rt_B;
  logic [n-1:0] o_rs_data_A;
  logic [n-1:0] o_rt_data_A;
  logic [n-1:0] o_rs_data_B;
  logic [n-1:0] o_rt_data_B;
  logic [a-1:0] i_rd_A;
  logic [a-1:0] i_rd_B;
  logic [n-1:0] i_wdata_A;
  logic [n-1:0] i_wdata_B;
  logic         i_rd_we_A;
  logic         i_rd_we_B;
  logic         i_alloc_we;
  logic [a-1:0] i_alloc_rd;
  logic [R-1:0] o_pending;

  modport master (
    output gwe, i_rs_A, i_rt_A, i_rs_B, i_rt_B,
    output i_rd_A, i_rd_B, i_wdata_A, i_wdata_B, i_rd_we_A, i_rd_we_B,
    output i_alloc_we, i_alloc_rd,
    input  o_rs_data_A, o_rt_data_A, o_rs_data_B, o_rt_data_B, o_pending
  );

  modport slave (
    input  gwe, i_rs_A, i_rt_A, i_rs_B, i_rt_B,
    input  i_rd_A, i_rd_B, i_wdata_A, i_wdata_B, i_rd_we_A, i_rd_we_B,
    input  i_alloc_we, i_alloc_rd,
    output o_rs_data_A, o_rt_data_A, o_rs_data_B, o_rt_data_B, o_pending
  );
endinterface

// File: rtl/lc4_regfile_ss.sv
// Dual-write, quad-read register file for the two-pipe LC4 core, with optional
// same-cycle write forwarding and a pending-producer scoreboard.
module lc4_regfile_ss #(
  parameter int n      = 16,
  parameter int a      = 3,
  parameter int BYPASS = 1
) (
  input  logic               clk,
  input  logic               rst,
  lc4_regfile_ss_if.slave    bus
);
  localparam int R = 1 << a;

  logic [n-1:0] regs_q [R];
  logic [n-1:0] regs_d [R];
  logic [R-1:0] pending_q;
  logic [R-1:0] pending_d;

  logic         wr_en_A;
  logic         wr_en_B;
  logic [a-1:0] rd_sel  [4];
  logic [n-1:0] rd_data [4];

  assign wr_en_A = bus.gwe & bus.i_rd_we_A;
  assign wr_en_B = bus.gwe & bus.i_rd_we_B;

  // B is the younger instruction, so its write is applied last and wins.
  always_comb begin
    regs_d    = regs_q;
    pending_d = pending_q;
    if (wr_en_A) regs_d[bus.i_rd_A] = bus.i_wdata_A;
    if (wr_en_B) regs_d[bus.i_rd_B] = bus.i_wdata_B;
    if (bus.gwe) begin
      for (int k = 0; k < R; k++) begin
        if (bus.i_alloc_we && (bus.i_alloc_rd == a'(k))) begin
          pending_d[k] = 1'b1;
        end else if ((wr_en_A && (bus.i_rd_A == a'(k))) ||
                     (wr_en_B && (bus.i_rd_B == a'(k)))) begin
          pending_d[k] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < R; k++) begin
        regs_q[k] <= '0;
      end
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

  // Forwarding checks B after A so B's data takes priority on a double match.
  always_comb begin
    rd_sel[0] = bus.i_rs_A;
    rd_sel[1] = bus.i_rt_A;
    rd_sel[2] = bus.i_rs_B;
    rd_sel[3] = bus.i_rt_B;
    for (int p = 0; p < 4; p++) begin
      rd_data[p] = regs_q[rd_sel[p]];
      if (BYPASS != 0) begin
        if (wr_en_A && (bus.i_rd_A == rd_sel[p])) rd_data[p] = bus.i_wdata_A;
        if (wr_en_B && (bus.i_rd_B == rd_sel[p])) rd_data[p] = bus.i_wdata_B;
      end
    end
  end

  assign bus.o_rs_data_A = rd_data[0];
  assign bus.o_rt_data_A = rd_data[1];
  assign bus.o_rs_data_B = rd_data[2];
  assign bus.o_rt_data_B = rd_data[3];
  assign bus.o_pending   = pending_q;
endmodule

// File: tb/tb_lc4_regfile_ss.sv
// Bench for lc4_regfile_ss: directed scenarios plus randomized traffic, run on a
// forwarding instance and a non-forwarding instance sharing the same stimulus.
module tb_lc4_regfile_ss;
  logic clk;
  logic rst;

  int checks   = 0;
  int failures = 0;

  lc4_regfile_ss_if #(.n(16), .a(3)) bus ();
  lc4_regfile_ss_if #(.n(16), .a(3)) bus_nb ();

  lc4_regfile_ss #(.n(16), .a(3), .BYPASS(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  lc4_regfile_ss #(.n(16), .a(3), .BYPASS(0)) dut_nb (
    .clk (clk),
    .rst (rst),
    .bus (bus_nb)
  );

  assign bus_nb.gwe        = bus.gwe;
  assign bus_nb.i_rs_A     = bus.i_rs_A;
  assign bus_nb.i_rt_A     = bus.i_rt_A;
  assign bus_nb.i_rs_B     = bus.i_rs_B;
  assign bus_nb.i_rt_B     = bus.i_rt_B;
  assign bus_nb.i_rd_A     = bus.i_rd_A;
  assign bus_nb.i_rd_B     = bus.i_rd_B;
  assign bus_nb.i_wdata_A  = bus.i_wdata_A;
  assign bus_nb.i_wdata_B  = bus.i_wdata_B;
  assign bus_nb.i_rd_we_A  = bus.i_rd_we_A;
  assign bus_nb.i_rd_we_B  = bus.i_rd_we_B;
  assign bus_nb.i_alloc_we = bus.i_alloc_we;
  assign bus_nb.i_alloc_rd = bus.i_alloc_rd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural register contents and pending set.
  logic [15:0] mem_m [8];
  logic [7:0]  pend_m;

  logic [15:0] obs_b [4];
  logic [15:0] obs_n [4];
  logic [2:0]  sels  [4];

  always_comb begin
    obs_b[0] = bus.o_rs_data_A;
    obs_b[1] = bus.o_rt_data_A;
    obs_b[2] = bus.o_rs_data_B;
    obs_b[3] = bus.o_rt_data_B;
    obs_n[0] = bus_nb.o_rs_data_A;
    obs_n[1] = bus_nb.o_rt_data_A;
    obs_n[2] = bus_nb.o_rs_data_B;
    obs_n[3] = bus_nb.o_rt_data_B;
    sels[0]  = bus.i_rs_A;
    sels[1]  = bus.i_rt_A;
    sels[2]  = bus.i_rs_B;
    sels[3]  = bus.i_rt_B;
  end

  task automatic model_clear();
    for (int k = 0; k < 8; k++) mem_m[k] = 16'h0000;
    pend_m = 8'h00;
  endtask

  task automatic model_commit();
    if (bus.gwe) begin
      if (bus.i_rd_we_A) pend_m[bus.i_rd_A] = 1'b0;
      if (bus.i_rd_we_B) pend_m[bus.i_rd_B] = 1'b0;
      if (bus.i_alloc_we) pend_m[bus.i_alloc_rd] = 1'b1;
      if (bus.i_rd_we_A) mem_m[bus.i_rd_A] = bus.i_wdata_A;
      if (bus.i_rd_we_B) mem_m[bus.i_rd_B] = bus.i_wdata_B;
    end
  endtask

  function automatic logic [15:0] exp_read(input logic [2:0] sel, input bit byp);
    if (byp && bus.gwe && bus.i_rd_we_B && bus.i_rd_B == sel) return bus.i_wdata_B;
    if (byp && bus.gwe && bus.i_rd_we_A && bus.i_rd_A == sel) return bus.i_wdata_A;
    return mem_m[sel];
  endfunction

  task automatic idle();
    bus.gwe        = 1'b1;
    bus.i_rd_we_A  = 1'b0;
    bus.i_rd_we_B  = 1'b0;
    bus.i_alloc_we = 1'b0;
    bus.i_rd_A     = 3'd0;
    bus.i_rd_B     = 3'd0;
    bus.i_wdata_A  = 16'h0000;
    bus.i_wdata_B  = 16'h0000;
    bus.i_alloc_rd = 3'd0;
  endtask

  task automatic tick();
    if (rst) model_commit();
    else model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    bus.i_rs_A = 3'd0; bus.i_rt_A = 3'd0; bus.i_rs_B = 3'd0; bus.i_rt_B = 3'd0;
    model_clear();
    tick();
    tick();
    checks++;
    if (bus.o_pending !== 8'h00) begin
      failures++; $display("FAIL reset_pending got=%h exp=00", bus.o_pending);
    end
    rst = 1'b1;
    bus.i_rd_we_A = 1'b1; bus.i_rd_A = 3'd3; bus.i_wdata_A = 16'h1234;
    bus.i_alloc_we = 1'b1; bus.i_alloc_rd = 3'd3;
    tick();
    idle();
    bus.i_rs_A = 3'd3; bus.i_rt_B = 3'd3;
    #1;
    checks++;
    if (bus.o_rs_data_A !== 16'h1234 || bus.o_pending !== 8'h08) begin
      failures++;
      $display("FAIL reset_prewrite got=%h/%h exp=1234/08", bus.o_rs_data_A, bus.o_pending);
    end
    // Asynchronous assertion mid-cycle, well away from any clock edge.
    rst = 1'b0;
    model_clear();
    #1;
    checks++;
    if (bus.o_rs_data_A !== 16'h0000 || bus.o_rt_data_B !== 16'h0000 ||
        bus_nb.o_rs_data_A !== 16'h0000) begin
      failures++;
      $display("FAIL reset_async_read got=%h/%h/%h exp=0000", bus.o_rs_data_A,
               bus.o_rt_data_B, bus_nb.o_rs_data_A);
    end
    checks++;
    if (bus.o_pending !== 8'h00 || bus_nb.o_pending !== 8'h00) begin
      failures++;
      $display("FAIL reset_async_pending got=%h/%h exp=00", bus.o_pending, bus_nb.o_pending);
    end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.o_rs_data_A !== 16'h0000 || bus.o_pending !== 8'h00) begin
      failures++;
      $display("FAIL reset_release got=%h/%h exp=0000/00", bus.o_rs_data_A, bus.o_pending);
    end
    $display("test_reset done");
  endtask

  task automatic test_dual_write();
    idle();
    bus.i_rd_we_A = 1'b1; bus.i_rd_A = 3'd1; bus.i_wdata_A = 16'hAAAA;
    bus.i_rd_we_B = 1'b1; bus.i_rd_B = 3'd2; bus.i_wdata_B = 16'h5555;
    tick();
    idle();
    bus.i_rs_A = 3'd1; bus.i_rt_B = 3'd2;
    #1;
    checks++;
    if (bus.o_rs_data_A !== 16'hAAAA || bus_nb.o_rs_data_A !== 16'hAAAA) begin
      failures++;
      $display("FAIL dual_rsA got=%h/%h exp=aaaa", bus.o_rs_data_A, bus_nb.o_rs_data_A);
    end
    checks++;
    if (bus.o_rt_data_B !== 16'h5555 || bus_nb.o_rt_data_B !== 16'h5555) begin
      failures++;
      $display("FAIL dual_rtB got=%h/%h exp=5555", bus.o_rt_data_B, bus_nb.o_rt_data_B);
    end
    $display("test_dual_write done");
  endtask

  task automatic test_collision();
    idle();
    bus.i_rd_we_A = 1'b1; bus.i_rd_A = 3'd4; bus.i_wdata_A = 16'h1111;
    bus.i_rd_we_B = 1'b1; bus.i_rd_B = 3'd4; bus.i_wdata_B = 16'h2222;
    bus.i_rs_A = 3'd4; bus.i_rt_A = 3'd4; bus.i_rs_B = 3'd4; bus.i_rt_B = 3'd4;
    #1;
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (obs_b[p] !== 16'h2222 || obs_n[p] !== 16'h0000) begin
        failures++;
        $display("FAIL collide_same port%0d got=%h/%h exp=2222/0000", p, obs_b[p], obs_n[p]);
      end
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.o_rt_data_A !== 16'h2222 || bus_nb.o_rt_data_A !== 16'h2222) begin
      failures++;
      $display("FAIL collide_after got=%h/%h exp=2222", bus.o_rt_data_A, bus_nb.o_rt_data_A);
    end
    $display("test_collision done");
  endtask

  task automatic test_bypass();
    idle();
    bus.i_rd_we_A = 1'b1; bus.i_rd_A = 3'd5; bus.i_wdata_A = 16'h0007;
    tick();
    idle();
    bus.i_rd_we_B = 1'b1; bus.i_rd_B = 3'd5; bus.i_wdata_B = 16'h00FF;
    bus.i_rt_A = 3'd5;
    #1;
    checks++;
    if (bus.o_rt_data_A !== 16'h00FF) begin
      failures++; $display("FAIL bypass_on got=%h exp=00ff", bus.o_rt_data_A);
    end
    checks++;
    if (bus_nb.o_rt_data_A !== 16'h0007) begin
      failures++; $display("FAIL bypass_off got=%h exp=0007", bus_nb.o_rt_data_A);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.o_rt_data_A !== 16'h00FF || bus_nb.o_rt_data_A !== 16'h00FF) begin
      failures++;
      $display("FAIL bypass_next got=%h/%h exp=00ff", bus.o_rt_data_A, bus_nb.o_rt_data_A);
    end
    $display("test_bypass done");
  endtask

  task automatic test_gwe();
    idle();
    bus.gwe = 1'b0;
    bus.i_rd_we_A = 1'b1; bus.i_rd_A = 3'd6; bus.i_wdata_A = 16'hBEEF;
    bus.i_rd_we_B = 1'b1; bus.i_rd_B = 3'd6; bus.i_wdata_B = 16'hBEEF;
    bus.i_alloc_we = 1'b1; bus.i_alloc_rd = 3'd6;
    bus.i_rs_B = 3'd6;
    #1;
    checks++;
    if (bus.o_rs_data_B !== 16'h0000) begin
      failures++; $display("FAIL gwe_nobypass got=%h exp=0000", bus.o_rs_data_B);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.o_rs_data_B !== 16'h0000 || bus_nb.o_rs_data_B !== 16'h0000) begin
      failures++;
      $display("FAIL gwe_hold got=%h/%h exp=0000", bus.o_rs_data_B, bus_nb.o_rs_data_B);
    end
    checks++;
    if (bus.o_pending[6] !== 1'b0) begin
      failures++; $display("FAIL gwe_pending got=%b exp=0", bus.o_pending[6]);
    end
    $display("test_gwe done");
  endtask

  task automatic test_scoreboard();
    idle();
    bus.i_alloc_we = 1'b1; bus.i_alloc_rd = 3'd7;
    tick();
    idle();
    #1;
    checks++;
    if (bus.o_pending !== 8'h80) begin
      failures++; $display("FAIL sb_alloc got=%h exp=80", bus.o_pending);
    end
    bus.i_alloc_we = 1'b1; bus.i_alloc_rd = 3'd7;
    bus.i_rd_we_A = 1'b1; bus.i_rd_A = 3'd7; bus.i_wdata_A = 16'h0777;
    tick();
    idle();
    #1;
    checks++;
    if (bus.o_pending[7] !== 1'b1) begin
      failures++; $display("FAIL sb_alloc_and_write got=%b exp=1", bus.o_pending[7]);
    end
    bus.i_rd_we_B = 1'b1; bus.i_rd_B = 3'd7; bus.i_wdata_B = 16'h0778;
    #1;
    checks++;
    if (bus.o_pending[7] !== 1'b1) begin
      failures++; $display("FAIL sb_not_bypassed got=%b exp=1", bus.o_pending[7]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.o_pending !== 8'h00 || bus_nb.o_pending !== 8'h00) begin
      failures++;
      $display("FAIL sb_clear got=%h/%h exp=00", bus.o_pending, bus_nb.o_pending);
    end
    $display("test_scoreboard done");
  endtask

  task automatic test_random();
    int bad;
    for (int i = 0; i < 400; i++) begin
      bus.gwe        = ($urandom_range(0, 3) != 0);
      bus.i_rd_we_A  = $urandom_range(0, 1);
      bus.i_rd_we_B  = $urandom_range(0, 1);
      bus.i_alloc_we = ($urandom_range(0, 2) == 0);
      bus.i_rd_A     = 3'($urandom_range(0, 7));
      bus.i_rd_B     = 3'($urandom_range(0, 7));
      bus.i_alloc_rd = 3'($urandom_range(0, 7));
      bus.i_wdata_A  = 16'($urandom);
      bus.i_wdata_B  = 16'($urandom);
      bus.i_rs_A     = 3'($urandom_range(0, 7));
      bus.i_rt_A     = 3'($urandom_range(0, 7));
      bus.i_rs_B     = 3'($urandom_range(0, 7));
      bus.i_rt_B     = 3'($urandom_range(0, 7));
      #1;
      bad = 0;
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (obs_b[p] !== exp_read(sels[p], 1'b1)) begin
          failures++; bad++;
          $display("FAIL rand_byp cyc%0d port%0d sel=%0d got=%h exp=%h", i, p, sels[p],
                   obs_b[p], exp_read(sels[p], 1'b1));
        end
        checks++;
        if (obs_n[p] !== exp_read(sels[p], 1'b0)) begin
          failures++; bad++;
          $display("FAIL rand_nobyp cyc%0d port%0d sel=%0d got=%h exp=%h", i, p, sels[p],
                   obs_n[p], exp_read(sels[p], 1'b0));
        end
      end
      checks++;
      if (bus.o_pending !== pend_m || bus_nb.o_pending !== pend_m) begin
        failures++; bad++;
        $display("FAIL rand_pending cyc%0d got=%h/%h exp=%h", i, bus.o_pending,
                 bus_nb.o_pending, pend_m);
      end
      tick();
    end
    $display("test_random done");
  endtask

  initial begin
    rst = 1'b0;
    idle();
    test_reset();
    test_dual_write();
    test_collision();
    test_bypass();
    test_gwe();
    test_scoreboard();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lc4_regfile_ss.md
# lc4_regfile_ss

Dual-issue register file for the superscalar LC4 datapath. It provides 2^a registers of n bits, two write ports and four read ports (rs/rt for pipes A and B), with optional same-cycle write-to-read bypass. A pending-write scoreboard tracks registers that have an outstanding producer. It replaces the single-issue 8×16 register file in the two-pipe core and sits between decode (reads, allocation) and writeback (writes).

## Interface
Parameters:
- n, 16, register width in bits
- a, 3, register-address width; register count R = 2^a
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- gwe  input  1  global write enable; gates every state update
- i_rs_A, i_rt_A, i_rs_B, i_rt_B  input  a  read selectors
- o_rs_data_A, o_rt_data_A, o_rs_data_B, o_rt_data_B  output  n  read data
- i_rd_A, i_rd_B  input  a  write selectors
- i_wdata_A, i_wdata_B  input  n  write data
- i_rd_we_A, i_rd_we_B  input  1  write enables
- i_alloc_we  input  1  mark register i_alloc_rd pending (issue of a producer)
- i_alloc_rd  input  a  register to mark pending
- o_pending  output  R  bit k = 1 while register k has an outstanding producer

## Operation
- Storage: R registers of n bits each; reset value 0. o_pending resets to all zeros.
- Effective write: port X writes when i_rd_we_X = 1 and gwe = 1. The value lands in register i_rd_X at the rising edge.
- Write collision: when A and B write the same register in one cycle, B wins. B is the younger instruction. A's data is discarded.
- Reads: combinational, with no read-port conflicts. All four ports may select any register, including the same one.
- Bypass (BYPASS=1): if a read selector matches an effective write this cycle, the read returns that write's data. If both A and B match, B's data is returned. With gwe=0 there is no effective write, so no bypass occurs.
- BYPASS=0: reads always return the stored value. New data is visible the cycle after the write.
- Scoreboard, per register k, evaluated at each edge with gwe=1:
  - Set if i_alloc_we=1 and i_alloc_rd=k.
  - Otherwise cleared if either effective write targets k.
  - Otherwise held.
  - Simultaneous alloc and write to the same k leaves it set, because the newer producer is outstanding.
- With gwe=0, registers and scoreboard hold regardless of other inputs.
- o_pending is registered. It is not bypassed and reflects state after the last edge.
- Width rules: no arithmetic. Selectors are exactly a bits, so every value maps to a valid register.

## Timing
- Read latency: 0 cycles (combinational from selectors and register state).
- Write latency: stored at the edge ending the write cycle. With BYPASS=1 the data is visible the same cycle; with BYPASS=0 it is visible the next cycle.
- Scoreboard latency: o_pending changes one cycle after the alloc or write cycle.
- Reset: takes effect immediately on rst falling, without waiting for clk. It clears all registers and o_pending mid-operation; writes in flight that cycle are lost. While rst=0, reads return 0, except bypassed data when BYPASS=1.
- Release: the first edge after rst rises performs normal updates.
- No handshake. Writers and allocators must not depend on backpressure.

## Test plan
- Reset/read: assert rst=0 mid-run after writing R3=0x1234, then release. All read ports show 0x0000 and o_pending=0 immediately, without waiting for clk.
- Dual write + readback: A writes R1=0xAAAA and B writes R2=0x5555 with gwe=1. Next cycle rs_A=1, rt_B=2 read 0xAAAA and 0x5555.
- Collision: A writes R4=0x1111 and B writes R4=0x2222 in the same cycle. R4 reads 0x2222 afterwards. With BYPASS=1 all ports selecting R4 read 0x2222 that same cycle.
- Bypass vs no bypass: R5=0x0007, then B writes R5=0x00FF while rt_A=5. Same-cycle read is 0x00FF with BYPASS=1 and 0x0007 with BYPASS=0; both read 0x00FF next cycle.
- gwe gating: gwe=0 with writes to R6=0xBEEF and alloc R6. R6 is unchanged, no bypass occurs, and o_pending[6] stays 0.
- Scoreboard: alloc R7, giving o_pending[7]=1 next cycle. Then alloc R7 and A writes R7 in the same cycle, leaving o_pending[7]=1. Then B writes R7 alone, giving o_pending[7]=0 next cycle.
